// File: rtl/im_pkg.sv
// Shared types, constants and the fetch fault check
// for the instruction memory fetch block.
package im_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0000;

   // A fetch faults when it is not word aligned or
   // when any address bit above the array range is set.
   function automatic logic fetch_fault(
      input logic [1:0] lsb,
      input logic       hi
   );
      return (lsb != 2'b00) || hi;
   endfunction

endpackage

// File: rtl/im_array.sv
// DEPTH x 32 word array: one synchronous write port,
// one combinational read port.
module im_array #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [31:0]              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH] = '{default: '0};

   // Load-port write; contents are never cleared by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/im_fetch.sv
// Instruction memory with req/valid fetch handshake,
// configurable wait states and a program-load port.
module im_fetch import im_pkg::*; #(
   parameter int          ADDR_W      = 32,
   parameter int          DEPTH       = 64,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] FAULT_WORD  = NOP
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic [ADDR_W-1:0]        addr,
   output logic                     ready,
   output logic                     valid,
   output logic [31:0]              data,
   output logic                     fault,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [31:0]              prog_data
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WS_INIT =
      4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam state_t GO =
      (WAIT_STATES > 0) ? WAIT : RESP;

   state_t      state;
   state_t      nxt;
   logic [3:0]  cnt;
   logic        acc;
   logic        hi;
   logic        flt;
   logic [31:0] rd_data;
   logic [31:0] hold_data;
   logic        hold_fault;
   logic [31:0] last_data;

   if (ADDR_W > IDX_W + 2) begin : g_hi
      assign hi = |addr[ADDR_W-1:IDX_W+2];
   end else begin : g_nohi
      assign hi = 1'b0;
   end

   assign flt   = fetch_fault(addr[1:0], hi);
   assign ready = (state != WAIT);
   assign valid = (state == RESP);
   assign acc   = req && (state != WAIT);
   assign data  = valid ? hold_data : last_data;
   assign fault = valid && hold_fault;

   im_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (addr[IDX_W+1:2]),
      .rdata (rd_data)
   );

   // State register and wait-state down counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (acc && (WAIT_STATES > 0)) begin
            cnt <= WS_INIT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next-state: accepts from IDLE or RESP, WAIT drains counter.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (acc) nxt = GO;
         WAIT: if (cnt == 4'd0) nxt = RESP;
         RESP: nxt = acc ? GO : IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Capture the fetch on accept (read-first vs. load port);
   // remember the last response so data holds between valids.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data  <= FAULT_WORD;
         hold_fault <= 1'b0;
         last_data  <= FAULT_WORD;
      end else begin
         if (acc) begin
            hold_data  <= flt ? FAULT_WORD : rd_data;
            hold_fault <= flt;
         end
         if (valid) begin
            last_data <= hold_data;
         end
      end
   end

endmodule

// File: tb/tb_im_fetch.sv
// Directed self-checking bench for im_fetch with
// WAIT_STATES = 0, 2 and 3 instances on shared inputs.
module tb_im_fetch;
   import im_pkg::*;

   localparam logic [31:0] W0  = 32'h3C01_1000;
   localparam logic [31:0] W1  = 32'h2008_0020;
   localparam logic [31:0] W2  = 32'h2009_0044;
   localparam logic [31:0] W63 = 32'h0800_003F;
   localparam logic [31:0] WN  = 32'hAC15_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [31:0] prog_data;

   logic        rdy0, vld0, flt0;
   logic        rdy2, vld2, flt2;
   logic        rdy3, vld3, flt3;
   logic [31:0] dat0, dat2, dat3;

   int total = 0;
   int bad   = 0;
   int n;
   logic seen;

   always #5 clk = ~clk;

   im_fetch #(
      .ADDR_W(32), .DEPTH(64), .WAIT_STATES(0), .FAULT_WORD(NOP)
   ) u0 (
      .clk(clk), .rst(rst), .req(req), .addr(addr),
      .ready(rdy0), .valid(vld0), .data(dat0), .fault(flt0),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   im_fetch #(
      .ADDR_W(32), .DEPTH(64), .WAIT_STATES(2), .FAULT_WORD(NOP)
   ) u2 (
      .clk(clk), .rst(rst), .req(req), .addr(addr),
      .ready(rdy2), .valid(vld2), .data(dat2), .fault(flt2),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   im_fetch #(
      .ADDR_W(32), .DEPTH(64), .WAIT_STATES(3), .FAULT_WORD(NOP)
   ) u3 (
      .clk(clk), .rst(rst), .req(req), .addr(addr),
      .ready(rdy3), .valid(vld3), .data(dat3), .fault(flt3),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      req = 1'b0;
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      step();
      prog_we   = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req       = 1'b0;
      addr      = '0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      step();
      step();
      chk("rst_ready", 32'(rdy0), 32'd1);
      chk("rst_valid", 32'(vld0), 32'd0);
      chk("rst_data",  dat0, 32'h0);
      chk("rst_fault", 32'(flt0), 32'd0);
      rst = 1'b0;

      load(6'd0, W0);
      load(6'd1, W1);
      load(6'd2, W2);
      load(6'd63, W63);

      // single fetch, zero wait states
      req  = 1'b1;
      addr = 32'h4;
      step();
      chk("ws0_valid", 32'(vld0), 32'd1);
      chk("ws0_data",  dat0, W1);
      chk("ws0_fault", 32'(flt0), 32'd0);
      req = 1'b0;
      step();
      chk("ws0_pulse", 32'(vld0), 32'd0);
      chk("ws0_hold",  dat0, W1);

      // back-to-back fetches
      req  = 1'b1;
      addr = 32'h0;
      step();
      chk("b2b_v0", 32'(vld0), 32'd1);
      chk("b2b_d0", dat0, W0);
      addr = 32'h4;
      step();
      chk("b2b_v1", 32'(vld0), 32'd1);
      chk("b2b_d1", dat0, W1);
      addr = 32'h8;
      step();
      chk("b2b_v2", 32'(vld0), 32'd1);
      chk("b2b_d2", dat0, W2);
      idle(1);
      chk("b2b_end", 32'(vld0), 32'd0);
      idle(6);

      // two wait states, req held through the wait
      req  = 1'b1;
      addr = 32'h4;
      step();
      addr = 32'h8;
      chk("ws2_rdy_a", 32'(rdy2), 32'd0);
      chk("ws2_vld_a", 32'(vld2), 32'd0);
      step();
      chk("ws2_rdy_b", 32'(rdy2), 32'd0);
      chk("ws2_vld_b", 32'(vld2), 32'd0);
      step();
      chk("ws2_vld_c", 32'(vld2), 32'd1);
      chk("ws2_rdy_c", 32'(rdy2), 32'd1);
      chk("ws2_data",  dat2, W1);
      step();
      req = 1'b0;
      chk("ws2_acc2_rdy", 32'(rdy2), 32'd0);
      chk("ws2_acc2_vld", 32'(vld2), 32'd0);
      step();
      chk("ws2_hold", dat2, W1);
      chk("ws2_hold_flt", 32'(flt2), 32'd0);
      step();
      chk("ws2_vld2", 32'(vld2), 32'd1);
      chk("ws2_data2", dat2, W2);
      idle(6);

      // faults
      req  = 1'b1;
      addr = 32'h6;
      step();
      chk("mis_valid", 32'(vld0), 32'd1);
      chk("mis_fault", 32'(flt0), 32'd1);
      chk("mis_data",  dat0, 32'h0);
      addr = 32'h100;
      step();
      chk("oor_valid", 32'(vld0), 32'd1);
      chk("oor_fault", 32'(flt0), 32'd1);
      addr = 32'hFC;
      step();
      chk("top_fault", 32'(flt0), 32'd0);
      chk("top_data",  dat0, W63);
      idle(1);
      chk("flt_idle",  32'(flt0), 32'd0);
      chk("top_hold",  dat0, W63);
      idle(6);

      // load and fetch of the same word in one cycle
      req       = 1'b1;
      addr      = 32'h8;
      prog_we   = 1'b1;
      prog_addr = 6'd2;
      prog_data = WN;
      step();
      prog_we = 1'b0;
      chk("rf_old", dat0, W2);
      step();
      chk("rf_new", dat0, WN);
      idle(1);

      // asynchronous reset between clock edges
      #3;
      rst = 1'b1;
      #1;
      chk("arst_ready", 32'(rdy0), 32'd1);
      chk("arst_valid", 32'(vld0), 32'd0);
      chk("arst_data",  dat0, 32'h0);
      chk("arst_fault", 32'(flt0), 32'd0);
      #1;
      rst = 1'b0;
      idle(6);

      // reset while in WAIT drops the fetch
      req  = 1'b1;
      addr = 32'h4;
      step();
      req = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("wrst_ready", 32'(rdy3), 32'd1);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (vld3) seen = 1'b1;
      end
      chk("wrst_drop", 32'(seen), 32'd0);

      // fresh fetch after reset completes with 1+3 latency
      req  = 1'b1;
      addr = 32'h8;
      step();
      req = 1'b0;
      n   = 0;
      while (!vld3 && n < 10) begin
         step();
         n++;
      end
      chk("ws3_lat",  32'(n), 32'd3);
      chk("ws3_data", dat3, WN);
      chk("ws3_flt",  32'(flt3), 32'd0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
